// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The unit takes the slave side; the operand source and result consumer take the master side.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             acc_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;

   modport master (
      output in_valid, op, acc_mode, a, b, out_ready,
      input  in_ready, out_valid, out_data, out_zero
   );

   modport slave (
      input  in_valid, op, acc_mode, a, b, out_ready,
      output in_ready, out_valid, out_data, out_zero
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a single output stage, an optional accumulator
// feedback path and a saturating count of consumed results.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   logic_unit_pipe_if.slave bus,
   input  logic             acc_clr,
   output logic [WIDTH-1:0] acc_q,
   output logic [CNT_W-1:0] op_count
);
   localparam logic [2:0] OP_NOT  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_XNOR = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;
   localparam logic [2:0] OP_NOR  = 3'd6;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_zero_q;
   logic             in_ready_c;
   logic             acc_fire;
   logic             out_fire;
   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] result;

   // Pass-through backpressure: a consumed result frees the stage in the same cycle.
   assign in_ready_c    = !out_valid_q || bus.out_ready;
   assign acc_fire      = bus.in_valid && in_ready_c;
   assign out_fire      = out_valid_q && bus.out_ready;

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_zero  = out_zero_q;

   always_comb begin
      a_eff  = bus.acc_mode ? acc_q : bus.a;
      result = a_eff;
      case (bus.op)
         OP_NOT:  result = ~a_eff;
         OP_OR:   result = a_eff | bus.b;
         OP_AND:  result = a_eff & bus.b;
         OP_XOR:  result = a_eff ^ bus.b;
         OP_XNOR: result = ~(a_eff ^ bus.b);
         OP_NAND: result = ~(a_eff & bus.b);
         OP_NOR:  result = ~(a_eff | bus.b);
         default: result = a_eff;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_zero_q  <= 1'b1;
         acc_q       <= '0;
         op_count    <= '0;
      end else begin
         if (acc_fire) begin
            out_data_q  <= result;
            out_zero_q  <= ~|result;
            out_valid_q <= 1'b1;
         end else if (out_fire) begin
            out_valid_q <= 1'b0;
         end

         // Clear takes priority over write-back; the accepted beat already used the old value.
         if (acc_clr) begin
            acc_q <= '0;
         end else if (acc_fire && bus.acc_mode) begin
            acc_q <= result;
         end

         if (out_fire && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: truth-table reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_logic_unit_pipe;
   localparam int WIDTH = 8;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             acc_clr;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] op_count;

   logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

   logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .acc_clr  (acc_clr),
      .acc_q    (acc_q),
      .op_count (op_count)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Reference state
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_zero;
   logic [WIDTH-1:0] m_acc;
   int               m_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each opcode as a 2-input truth table indexed by {a_bit, b_bit}.
   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      logic [3:0] tt [8];
      logic [3:0] t;
      logic [WIDTH-1:0] r;
      tt[0] = 4'b0011; tt[1] = 4'b1110; tt[2] = 4'b1000; tt[3] = 4'b0110;
      tt[4] = 4'b1001; tt[5] = 4'b0111; tt[6] = 4'b0001; tt[7] = 4'b1100;
      t = tt[op];
      for (int i = 0; i < WIDTH; i++) r[i] = t[{x[i], y[i]}];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      logic             ready;
      logic             fire;
      logic [WIDTH-1:0] r;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_zero  = 1'b1;
         m_acc   = '0;
         m_cnt   = 0;
      end else begin
         ready = !m_valid || bus.out_ready;
         fire  = bus.in_valid && ready;
         r     = ref_op(bus.op, bus.acc_mode ? m_acc : bus.a, bus.b);
         if (m_valid && bus.out_ready && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         if (fire) begin
            m_data  = r;
            m_zero  = (r == 0);
            m_valid = 1'b1;
            if (bus.acc_mode) m_acc = r;
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (acc_clr) m_acc = '0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("model in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
         check("model out_data", 32'(bus.out_data), 32'(m_data));
         check("model out_zero", 32'(bus.out_zero), 32'(m_zero));
         check("model acc_q", 32'(acc_q), 32'(m_acc));
         check("model op_count", 32'(op_count), 32'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [2:0] op, input logic am, input logic [7:0] av, input logic [7:0] bv);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.acc_mode = am;
      bus.a        = av;
      bus.b        = bv;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] sweep_exp [8];
      logic [7:0] acc_b [4];
      logic [7:0] acc_exp [4];
      sweep_exp = '{8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5};
      acc_b     = '{8'h01, 8'h02, 8'h04, 8'h80};
      acc_exp   = '{8'h01, 8'h03, 8'h07, 8'h87};

      rst = 1'b1;
      acc_clr = 1'b0;
      bus.in_valid = 1'b0;
      bus.op = 3'd0;
      bus.acc_mode = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("reset out_valid", 32'(bus.out_valid), 0);
      check("reset out_data", 32'(bus.out_data), 0);
      check("reset out_zero", 32'(bus.out_zero), 1);
      check("reset in_ready", 32'(bus.in_ready), 1);
      rst = 1'b0;

      // Op sweep
      for (int i = 0; i < 8; i++) begin
         beat(3'(i), 1'b0, 8'hC5, 8'h3A);
         tick();
         check("sweep out_data", 32'(bus.out_data), 32'(sweep_exp[i]));
         check("sweep out_zero", 32'(bus.out_zero), 32'(i == 2 || i == 4 || i == 6));
         check("sweep out_valid", 32'(bus.out_valid), 1);
      end

      // Backpressure
      do_reset();
      bus.out_ready = 1'b0;
      beat(3'd1, 1'b0, 8'h0F, 8'hF0);
      tick();
      beat(3'd2, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) begin
         check("stall in_ready", 32'(bus.in_ready), 0);
         check("stall out_data", 32'(bus.out_data), 32'hFF);
         tick();
      end
      check("stall op_count", 32'(op_count), 0);
      bus.out_ready = 1'b1;
      #1;
      check("release in_ready", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      check("release out_data", 32'(bus.out_data), 0);
      check("release out_zero", 32'(bus.out_zero), 1);
      check("release op_count", 32'(op_count), 1);
      tick();
      check("drain out_valid", 32'(bus.out_valid), 0);
      check("drain op_count", 32'(op_count), 2);

      // Accumulate chain
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat(3'd1, 1'b1, 8'h55, acc_b[i]);
         tick();
         check("acc out_data", 32'(bus.out_data), 32'(acc_exp[i]));
      end
      check("acc acc_q", 32'(acc_q), 32'h87);
      beat(3'd3, 1'b1, 8'h55, 8'h87);
      tick();
      check("acc xor data", 32'(bus.out_data), 0);
      check("acc xor zero", 32'(bus.out_zero), 1);

      // Clear collision
      beat(3'd1, 1'b1, 8'h00, 8'hF0);
      tick();
      check("preload acc_q", 32'(acc_q), 32'hF0);
      beat(3'd7, 1'b1, 8'h0A, 8'h00);
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      bus.in_valid = 1'b0;
      check("collide out_data", 32'(bus.out_data), 32'hF0);
      check("collide acc_q", 32'(acc_q), 0);

      // Counter saturation
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i < 5) beat(3'd1, 1'b0, 8'(i), 8'h10);
         else bus.in_valid = 1'b0;
         tick();
         if (i > 0) check("sat op_count", 32'(op_count), (i > 3) ? 3 : i);
      end

      // Reset mid-stream
      bus.out_ready = 1'b1;
      beat(3'd0, 1'b1, 8'h00, 8'h00);
      tick();
      bus.out_ready = 1'b0;
      beat(3'd1, 1'b0, 8'h01, 8'h02);
      tick();
      check("pre-rst acc_q", 32'(acc_q), 32'hFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst out_valid", 32'(bus.out_valid), 0);
      check("rst out_data", 32'(bus.out_data), 0);
      check("rst out_zero", 32'(bus.out_zero), 1);
      check("rst acc_q", 32'(acc_q), 0);
      check("rst op_count", 32'(op_count), 0);
      bus.out_ready = 1'b1;
      beat(3'd1, 1'b0, 8'h12, 8'h21);
      tick();
      bus.in_valid = 1'b0;
      check("post-rst out_valid", 32'(bus.out_valid), 1);
      check("post-rst out_data", 32'(bus.out_data), 32'h33);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.op        = 3'($urandom_range(0, 7));
         bus.acc_mode  = 1'($urandom_range(0, 1));
         bus.a         = 8'($urandom);
         bus.b         = 8'($urandom);
         acc_clr       = ($urandom_range(0, 15) == 0);
         rst           = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      acc_clr = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
